sort_scheduler: RTL
===================

// Module: sort_scheduler
// PURPOSE
//  Serial sort controller. Loads N labelled elements into a local buffer and runs
//  odd-even transposition sort (N phases) through ONE shared external 2-input
//  compare/swap unit (input_2). Streams the sorted result out.
//  Trades throughput for area versus a full N-input network.
// PARAMETERS
//  DATA_WIDTH   8  width of each data word
//  LABEL_WIDTH  4  width of the label carried with each word
//  N            8  elements per sort job; even, >= 2
// PORTS
//  clk            in   1            clock, all logic on rising edge
//  rst            in   1            asynchronous reset, active-low (0 = reset)
//  in_valid       in   1            input element valid
//  in_ready       out  1            scheduler accepts element (LOAD state)
//  in_data        in   DATA_WIDTH   input element data
//  in_label       in   LABEL_WIDTH  input element label
//  out_valid      out  1            sorted element valid
//  out_ready      in   1            downstream accepts element
//  out_data       out  DATA_WIDTH   sorted element data
//  out_label      out  LABEL_WIDTH  sorted element label
//  out_last       out  1            high with element N-1 of the job
//  busy           out  1            high in ISSUE/DRAIN
//  err            out  1            sticky: cas_y_valid with nothing outstanding
//  cas_x_valid    out  1            pair issued to the compare/swap unit
//  cas_x_0/1      out  DATA_WIDTH   lower/upper buffer slot data
//  cas_x_label_0/1 out LABEL_WIDTH  lower/upper buffer slot labels
//  cas_y_valid    in   1            compare/swap result valid
//  cas_y_0/1      in   DATA_WIDTH   result for lower/upper slot
//  cas_y_label_0/1 in  LABEL_WIDTH  result labels for lower/upper slot
// BEHAVIOUR
//  - Reset: state=LOAD, all counters 0, err=0. cas_x_*, out_data, out_label,
//    out_valid, out_last and busy are 0. in_ready=1 in LOAD, including during reset.
//    Buffer contents are don't-care. The compare/swap unit shares rst, so its
//    in-flight results are flushed.
//  - LOAD: in_ready=1. Each in_valid&in_ready writes buffer[wr_cnt]; wr_cnt++.
//    After the Nth accept -> ISSUE, phase=0.
//  - ISSUE: one pair per cycle, cas_x_valid=1, issue index p=0..P-1.
//    Even phase: slots (2p,2p+1), P=N/2. Odd phase: slots (2p+1,2p+2), P=N/2-1.
//    After the last pair -> DRAIN. Pairs within a phase are disjoint, so they
//    issue back-to-back.
//  - Results return in issue order. Each cas_y_valid writes the pair at return
//    index r (cas_y_0->lower slot, cas_y_1->upper slot); r++. Write-back is
//    accepted in ISSUE or DRAIN.
//  - DRAIN: cas_x_valid=0. When r==P (the last result is written) ->
//    - if phase==N-1: OUT, rd_cnt=0.
//    - else: phase++, r=0, ISSUE on the next cycle.
//    The next phase never issues before the last write-back of the current one.
//  - A phase with P=0 (odd phase when N=2) is skipped in one cycle with no issue.
//  - Latency is never assumed; only cas_y_valid is counted.
//  - OUT: out_valid=1 with buffer[rd_cnt]; out_last=(rd_cnt==N-1).
//    Outputs hold stable while out_valid&!out_ready. Each handshake does rd_cnt++.
//    After the handshake with out_last=1 -> LOAD.
//  - err: set by cas_y_valid when r>=P, or when the state is LOAD/OUT. That
//    result is dropped and the buffer is unchanged. err is cleared only by reset.
//  - in_valid outside LOAD is ignored (in_ready=0).
//  - Reset mid-job aborts immediately; the partial job is discarded.
//  - Counters and phase are sized $clog2(N)+1 and never wrap within a job.
// TESTING
//  1 N=8, CAS model latency 1, ascending. Load 7..0 with labels 0..7
//    -> out 0..7, labels 7..0; out_last on the 8th beat; err=0.
//  2 Already-sorted input 0..7 -> identical output. Exactly 28 cas_x_valid pulses
//    (4 even phases x4 + 4 odd phases x3).
//  3 CAS model latency 3 -> same output as test 1. No cas_x_valid of phase k+1
//    appears before the final cas_y_valid of phase k.
//  4 out_ready pattern 1,0,0,1,... -> out_data, out_label and out_last stay stable
//    while stalled; no element lost or duplicated.
//  5 rst=0 during ISSUE of phase 3 -> all outputs 0 and busy=0 at once.
//    After release, a full job of 3,1,2,0,7,5,6,4 sorts to 0..7.
//  6 Spurious cas_y_valid in LOAD -> err=1 and stays 1. The following job still
//    sorts correctly.

Source files
------------

// File: rtl/sort_scheduler.sv
// Serial odd-even transposition sorter driving one shared external compare/swap unit.
// Latency: N load beats, N phases of issue plus result drain, then N output beats.
// Backpressure: in_ready only in LOAD; outputs hold while out_ready is low; CAS results counted, never timed.
module sort_scheduler #(
  parameter int DATA_WIDTH  = 8,
  parameter int LABEL_WIDTH = 4,
  parameter int N           = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [LABEL_WIDTH-1:0] in_label,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [LABEL_WIDTH-1:0] out_label,
  output logic                   out_last,
  output logic                   busy,
  output logic                   err,
  output logic                   cas_x_valid,
  output logic [DATA_WIDTH-1:0]  cas_x_0,
  output logic [DATA_WIDTH-1:0]  cas_x_1,
  output logic [LABEL_WIDTH-1:0] cas_x_label_0,
  output logic [LABEL_WIDTH-1:0] cas_x_label_1,
  input  logic                   cas_y_valid,
  input  logic [DATA_WIDTH-1:0]  cas_y_0,
  input  logic [DATA_WIDTH-1:0]  cas_y_1,
  input  logic [LABEL_WIDTH-1:0] cas_y_label_0,
  input  logic [LABEL_WIDTH-1:0] cas_y_label_1
);

  localparam int CW = $clog2(N) + 1;
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {S_LOAD, S_ISSUE, S_DRAIN, S_OUT} state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [CW-1:0]          r_wr_cnt;
  logic [CW-1:0]          r_rd_cnt;
  logic [CW-1:0]          r_phase;
  logic [CW-1:0]          r_iss;
  logic [CW-1:0]          r_ret;
  logic                   r_err;
  logic [DATA_WIDTH-1:0]  r_data  [N];
  logic [LABEL_WIDTH-1:0] r_label [N];

  logic [CW-1:0] w_pcnt;
  logic [IW-1:0] w_iss_lo;
  logic [IW-1:0] w_iss_hi;
  logic [IW-1:0] w_ret_lo;
  logic [IW-1:0] w_ret_hi;
  logic [IW-1:0] w_wr_idx;
  logic [IW-1:0] w_rd_idx;
  logic          w_in_fire;
  logic          w_out_fire;
  logic          w_wb;
  logic          w_spurious;
  logic          w_last_phase;
  logic          w_rd_last;
  logic          w_load_done;
  logic          w_phase_end;

  // Even phases compare (2p,2p+1) over N/2 pairs; odd phases (2p+1,2p+2) over N/2-1 pairs.
  assign w_pcnt       = r_phase[0] ? CW'(N/2 - 1) : CW'(N/2);
  assign w_iss_lo     = IW'((r_iss << 1) + CW'(r_phase[0]));
  assign w_iss_hi     = w_iss_lo + IW'(1);
  assign w_ret_lo     = IW'((r_ret << 1) + CW'(r_phase[0]));
  assign w_ret_hi     = w_ret_lo + IW'(1);
  assign w_wr_idx     = IW'(r_wr_cnt);
  assign w_rd_idx     = IW'(r_rd_cnt);
  assign w_last_phase = (r_phase == CW'(N-1));
  assign w_rd_last    = (r_rd_cnt == CW'(N-1));
  assign w_in_fire    = in_valid && (r_state == S_LOAD);
  assign w_load_done  = w_in_fire && (r_wr_cnt == CW'(N-1));
  assign w_out_fire   = out_ready && (r_state == S_OUT);
  // A result is only legal while a pair of the current phase is still outstanding.
  assign w_wb         = cas_y_valid && ((r_state == S_ISSUE) || (r_state == S_DRAIN)) && (r_ret < w_pcnt);
  assign w_spurious   = cas_y_valid && !w_wb;
  assign err          = r_err;

  // Data outputs are zeroed whenever their valid is low so idle/reset ports read 0.
  assign cas_x_0       = cas_x_valid ? r_data[w_iss_lo]  : '0;
  assign cas_x_1       = cas_x_valid ? r_data[w_iss_hi]  : '0;
  assign cas_x_label_0 = cas_x_valid ? r_label[w_iss_lo] : '0;
  assign cas_x_label_1 = cas_x_valid ? r_label[w_iss_hi] : '0;
  assign out_data      = out_valid   ? r_data[w_rd_idx]  : '0;
  assign out_label     = out_valid   ? r_label[w_rd_idx] : '0;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_LOAD;
    else      r_state <= w_next_state;
  end

  // Next-state and per-state outputs; phase end is decided here so counters follow the FSM.
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    busy         = 1'b0;
    cas_x_valid  = 1'b0;
    w_phase_end  = 1'b0;
    case (r_state)
      S_LOAD: begin
        in_ready = 1'b1;
        if (w_load_done) w_next_state = S_ISSUE;
      end
      S_ISSUE: begin
        busy = 1'b1;
        if (w_pcnt == '0) begin
          // Empty phase (odd phase with N=2) finishes without issuing.
          w_phase_end  = 1'b1;
          w_next_state = w_last_phase ? S_OUT : S_ISSUE;
        end else begin
          cas_x_valid = 1'b1;
          if (r_iss == w_pcnt - CW'(1)) w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (r_ret == w_pcnt) begin
          w_phase_end  = 1'b1;
          w_next_state = w_last_phase ? S_OUT : S_ISSUE;
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        out_last  = w_rd_last;
        if (out_ready && w_rd_last) w_next_state = S_LOAD;
      end
      default: w_next_state = S_LOAD;
    endcase
  end

  // Job counters, phase tracking and the sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
      r_phase  <= '0;
      r_iss    <= '0;
      r_ret    <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_in_fire) r_wr_cnt <= w_load_done ? '0 : r_wr_cnt + CW'(1);
      if (w_load_done) begin
        r_phase <= '0;
        r_iss   <= '0;
        r_ret   <= '0;
      end
      if (cas_x_valid) r_iss <= r_iss + CW'(1);
      if (w_wb)        r_ret <= r_ret + CW'(1);
      if (w_phase_end) begin
        r_iss <= '0;
        r_ret <= '0;
        if (w_last_phase) r_rd_cnt <= '0;
        else              r_phase  <= r_phase + CW'(1);
      end
      if (w_out_fire) r_rd_cnt <= w_rd_last ? '0 : r_rd_cnt + CW'(1);
      if (w_spurious) r_err <= 1'b1;
    end
  end

  // Element buffer: filled in LOAD, rewritten pairwise by compare/swap results.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_data[w_wr_idx]  <= in_data;
      r_label[w_wr_idx] <= in_label;
    end
    if (w_wb) begin
      r_data[w_ret_lo]  <= cas_y_0;
      r_data[w_ret_hi]  <= cas_y_1;
      r_label[w_ret_lo] <= cas_y_label_0;
      r_label[w_ret_hi] <= cas_y_label_1;
    end
  end

endmodule
